// File: rtl/run_length_serializer.sv
// run_length_serializer
// Queues 2-bit symbols in a small FIFO. Each symbol v goes out on the serial
// line x as v ones followed by one terminating zero, with frames back to back.
// After reset a single guard zero is sent first so the downstream run-length
// detector can sync. The line is held at zero when there is nothing to send.
module run_length_serializer #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    sym,
    input  logic          sym_valid,
    output logic          sym_ready,
    output logic          x,
    output logic          sym_done,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        IDLE  = 2'd1,
        ONES  = 2'd2,
        ZERO  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    rem_r;
    logic [1:0]    rem_s;
    logic          x_r;
    logic          sym_done_r;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [1:0]    mem_r [DEPTH];

    logic [LW-1:0] level_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    head_s;

    assign level_s = LW'(wr_ptr_r - rd_ptr_r);
    assign full_s  = (level_s == LW'(DEPTH));
    // Readiness depends only on registered occupancy, so a pop on the same
    // edge cannot make room for a push into a full FIFO.
    assign push_s  = sym_valid && !full_s;
    assign pop_s   = ((state_r == IDLE) || (state_r == ZERO)) && (level_s != {LW{1'b0}});
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    // Next-state logic: choose the next frame phase and the remaining-ones count.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        case (state_r)
            GUARD: begin
                state_s = IDLE;
            end
            IDLE, ZERO: begin
                if (pop_s) begin
                    if (head_s == 2'd0) begin
                        state_s = ZERO;
                        rem_s   = 2'd0;
                    end else begin
                        state_s = ONES;
                        rem_s   = head_s - 2'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ONES: begin
                if (rem_r == 2'd0) begin
                    state_s = ZERO;
                end else begin
                    rem_s = rem_r - 2'd1;
                end
            end
            default: begin
                state_s = GUARD;
                rem_s   = 2'd0;
            end
        endcase
    end

    // State register with registered Moore outputs for the serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= GUARD;
            rem_r      <= 2'd0;
            x_r        <= 1'b0;
            sym_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            x_r        <= (state_s == ONES);
            sym_done_r <= (state_s == ZERO);
        end
    end

    // FIFO pointer update; reset discards everything queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage write at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= sym;
            end
        end
    end

    assign sym_ready = !full_s;
    assign busy      = (state_r == ONES) || (state_r == ZERO) || (level_s != {LW{1'b0}});
    assign level     = level_s;
    assign x         = x_r;
    assign sym_done  = sym_done_r;

endmodule

// File: tb/tb_run_length_serializer.sv
// Directed bench for run_length_serializer. A small behavioural run-length
// detector watches x and reports the number of ones before each terminating 0.
module tb_run_length_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic       x;
    logic       sym_done;
    logic       busy;
    logic [2:0] level;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] det_ones   = 8'd0;
    logic [7:0] det_y      = 8'd0;
    int         det_frames = 0;
    int         last_frames;

    logic exp_x [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic sp_x  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic sp_d  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] lb_sym [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};

    run_length_serializer #(.DEPTH(4), .LW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .x         (x),
        .sym_done  (sym_done),
        .busy      (busy),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference detector: counts ones, reports the run on a terminating zero.
    always @(posedge clk) begin
        if (!rst) begin
            det_ones <= 8'd0;
        end else if (x) begin
            det_ones <= det_ones + 8'd1;
        end else begin
            if (sym_done) begin
                det_y      <= det_ones;
                det_frames <= det_frames + 1;
            end
            det_ones <= 8'd0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx_push;
        int idx_chk;
        logic ready_pre;

        rst = 1'b0; sym = 2'd0; sym_valid = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        chk("rst_x", 8'(x), 8'd0);
        chk("rst_done", 8'(sym_done), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_level", 8'(level), 8'd0);
        chk("rst_ready", 8'(sym_ready), 8'd1);

        // Release, guard zero, push 2 on the first edge
        rst = 1'b1;
        chk("guard_x", 8'(x), 8'd0);
        sym = 2'd2; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("g_idle_x", 8'(x), 8'd0);
        chk("g_level", 8'(level), 8'd1);
        tick(); chk("g_x1", 8'(x), 8'd1); chk("g_level0", 8'(level), 8'd0);
        tick(); chk("g_x2", 8'(x), 8'd1);
        tick(); chk("g_x3", 8'(x), 8'd0); chk("g_done", 8'(sym_done), 8'd1);
        tick(); chk("g_idle", 8'(x), 8'd0); chk("g_idle_done", 8'(sym_done), 8'd0);
        chk("g_idle_busy", 8'(busy), 8'd0);

        // Back-to-back 3,1,0
        sym = 2'd3; sym_valid = 1'b1;
        tick();
        chk("b2b_lvl1", 8'(level), 8'd1);
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                sym = 2'd1; sym_valid = 1'b1;
            end else if (i == 1) begin
                sym = 2'd0; sym_valid = 1'b1;
            end else begin
                sym_valid = 1'b0;
            end
            tick();
            chk("b2b_x", 8'(x), 8'(exp_x[i]));
            chk("b2b_done", 8'(sym_done), 8'(exp_d[i]));
            if (i == 1) chk("b2b_peak", 8'(level), 8'd2);
        end
        tick();
        chk("b2b_end_x", 8'(x), 8'd0);
        chk("b2b_end_busy", 8'(busy), 8'd0);

        // Backpressure: sym=3 offered for 10 cycles, 6 accepted
        last_frames = det_frames;
        idx_chk = 0;
        sym = 2'd3; sym_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                chk("bp_full_ready", 8'(sym_ready), 8'd0);
                chk("bp_full_level", 8'(level), 8'd4);
            end
            if (i == 6) chk("bp_pop_level", 8'(level), 8'd3);
            if (i == 7) chk("bp_refull_ready", 8'(sym_ready), 8'd0);
            if (det_frames != last_frames) begin
                chk("bp_frame_ones", det_y, 8'd3);
                last_frames = det_frames;
                idx_chk++;
            end
        end
        sym_valid = 1'b0;
        for (int i = 0; i < 60 && (busy || idx_chk < 6); i++) begin
            tick();
            if (det_frames != last_frames) begin
                chk("bp_frame_ones", det_y, 8'd3);
                last_frames = det_frames;
                idx_chk++;
            end
        end
        chk("bp_frames", 8'(idx_chk), 8'd6);
        chk("bp_idle_busy", 8'(busy), 8'd0);

        // Simultaneous push and pop: 1 then 2
        sym = 2'd1; sym_valid = 1'b1;
        tick();
        sym = 2'd2;
        tick();
        sym_valid = 1'b0;
        chk("sp_level", 8'(level), 8'd1);
        chk("sp_x0", 8'(x), 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sp_x", 8'(x), 8'(sp_x[i]));
            chk("sp_done", 8'(sym_done), 8'(sp_d[i]));
        end
        tick();
        chk("sp_end_busy", 8'(busy), 8'd0);

        // Mid-frame reset during the 2nd one of a v=3 frame
        sym = 2'd3; sym_valid = 1'b1;
        tick();
        sym = 2'd2;
        tick();
        sym = 2'd1;
        tick();
        sym_valid = 1'b0;
        chk("mr_x_before", 8'(x), 8'd1);
        chk("mr_level_before", 8'(level), 8'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_x_async", 8'(x), 8'd0);
        chk("mr_level", 8'(level), 8'd0);
        chk("mr_ready", 8'(sym_ready), 8'd1);
        chk("mr_busy", 8'(busy), 8'd0);
        tick();
        rst = 1'b1;
        chk("mr_guard", 8'(x), 8'd0);
        sym = 2'd1; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("mr_idle_x", 8'(x), 8'd0);
        chk("mr_level1", 8'(level), 8'd1);
        tick(); chk("mr_x1", 8'(x), 8'd1);
        tick(); chk("mr_x0", 8'(x), 8'd0); chk("mr_done", 8'(sym_done), 8'd1);
        tick(); chk("mr_det_y", det_y, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_quiet_x", 8'(x), 8'd0);
            chk("mr_quiet_busy", 8'(busy), 8'd0);
        end

        // Loopback through the detector: 1,2,3,0,3
        idx_push = 0;
        idx_chk = 0;
        last_frames = det_frames;
        for (int i = 0; i < 80 && idx_chk < 5; i++) begin
            sym_valid = (idx_push < 5);
            sym = (idx_push < 5) ? lb_sym[idx_push] : 2'd0;
            ready_pre = sym_ready;
            tick();
            if (sym_valid && ready_pre) idx_push++;
            if (det_frames != last_frames) begin
                chk("loop_y", det_y, 8'(lb_sym[idx_chk]));
                idx_chk++;
                last_frames = det_frames;
            end
        end
        sym_valid = 1'b0;
        chk("loop_count", 8'(idx_chk), 8'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
